// File: rtl/mem_access_stage.sv
// ============================================================================
// Module  : mem_access_stage
// Brief   : MEM pipeline stage on a req/gnt/rvalid data bus with sub-word
//           load extension, store lane steering and misalignment flags.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_access_stage #(
    parameter int DW   = 32,
    parameter int AW   = 32,
    parameter int RFAW = 5
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [3:0]           in_op,
    input  logic [AW-1:0]        in_addr,
    input  logic [DW-1:0]        in_wdata,
    input  logic [DW-1:0]        in_ex_result,
    input  logic                 in_rf_we,
    input  logic [RFAW-1:0]      in_rf_waddr,
    input  logic [31:0]          in_pc,
    output logic                 mem_req,
    output logic                 mem_we,
    output logic [DW/8-1:0]      mem_be,
    output logic [AW-1:0]        mem_addr,
    output logic [DW-1:0]        mem_wdata,
    input  logic                 mem_gnt,
    input  logic                 mem_rvalid,
    input  logic [DW-1:0]        mem_rdata,
    output logic                 out_valid,
    output logic [31:0]          out_pc,
    output logic                 out_rf_we,
    output logic [RFAW-1:0]      out_rf_waddr,
    output logic [DW-1:0]        out_rf_wdata,
    output logic                 out_adel,
    output logic                 out_ades,
    output logic                 stall_req,
    output logic [2+RFAW+DW-1:0] fwd_bus
);

    localparam int NB   = DW / 8;
    localparam int OFFW = $clog2(NB);
    localparam logic [DW-1:0] ALL_ONES = '1;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] REQ  = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    logic [1:0]      state;
    logic            ld_q, uns_q, rf_we_q, killed;
    logic [1:0]      size_q;
    logic [OFFW-1:0] lane_q;
    logic [RFAW-1:0] waddr_q;
    logic [31:0]     pc_q;
    logic [DW-1:0]   ex_q;

    logic            dec_ld, dec_st, dec_uns, dec_mis, accept, go_mem;
    logic [1:0]      dec_size;
    logic [NB-1:0]   be_base;
    logic [DW-1:0]   st_wdata;
    logic [DW-1:0]   shifted, mask, ld_data;
    logic            sgn;
    logic            busy;

    // Size encoding: 0 byte, 1 half, 2 word, 3 double. 64-bit ops decode as NOP on a 32-bit bus.
    always_comb begin
        dec_ld   = 1'b0;
        dec_st   = 1'b0;
        dec_uns  = 1'b0;
        dec_size = 2'd0;
        case (in_op)
            4'd1: dec_ld = 1'b1;
            4'd2: begin dec_ld = 1'b1; dec_uns = 1'b1; end
            4'd3: begin dec_ld = 1'b1; dec_size = 2'd1; end
            4'd4: begin dec_ld = 1'b1; dec_size = 2'd1; dec_uns = 1'b1; end
            4'd5: begin dec_ld = 1'b1; dec_size = 2'd2; end
            4'd6: dec_st = 1'b1;
            4'd7: begin dec_st = 1'b1; dec_size = 2'd1; end
            4'd8: begin dec_st = 1'b1; dec_size = 2'd2; end
            4'd9: if (DW == 64) begin dec_ld = 1'b1; dec_size = 2'd2; dec_uns = 1'b1; end
            4'd10: if (DW == 64) begin dec_ld = 1'b1; dec_size = 2'd3; end
            4'd11: if (DW == 64) begin dec_st = 1'b1; dec_size = 2'd3; end
            default: ;
        endcase
    end

    assign dec_mis = (dec_ld | dec_st) &
                     (((dec_size == 2'd1) & in_addr[0]) |
                      ((dec_size == 2'd2) & (|in_addr[1:0])) |
                      ((dec_size == 2'd3) & (|in_addr[2:0])));
    assign accept  = in_valid & (state == IDLE) & !flush & !rst;
    assign go_mem  = accept & (dec_ld | dec_st) & !dec_mis;

    always_comb begin
        be_base  = '1;
        st_wdata = in_wdata;
        case (dec_size)
            2'd0: begin be_base = NB'(1);  st_wdata = {NB{in_wdata[7:0]}}; end
            2'd1: begin be_base = NB'(3);  st_wdata = {(NB/2){in_wdata[15:0]}}; end
            2'd2: begin be_base = NB'(15); st_wdata = {(DW/32){in_wdata[31:0]}}; end
            default: ;
        endcase
    end

    // Load lane: shift addressed bytes down, then mask and sign-fill above the access width.
    always_comb begin
        shifted = mem_rdata >> {lane_q, 3'b000};
        case (size_q)
            2'd0:    mask = ALL_ONES >> (DW - 8);
            2'd1:    mask = ALL_ONES >> (DW - 16);
            2'd2:    mask = ALL_ONES >> (DW - 32);
            default: mask = ALL_ONES;
        endcase
        sgn     = !uns_q & (|(shifted & (mask ^ (mask >> 1))));
        ld_data = (shifted & mask) | (sgn ? ~mask : '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            mem_we       <= 1'b0;
            mem_be       <= '0;
            mem_addr     <= '0;
            mem_wdata    <= '0;
            out_valid    <= 1'b0;
            out_pc       <= '0;
            out_rf_we    <= 1'b0;
            out_rf_waddr <= '0;
            out_rf_wdata <= '0;
            out_adel     <= 1'b0;
            out_ades     <= 1'b0;
            ld_q         <= 1'b0;
            uns_q        <= 1'b0;
            size_q       <= 2'd0;
            lane_q       <= '0;
            rf_we_q      <= 1'b0;
            waddr_q      <= '0;
            pc_q         <= '0;
            ex_q         <= '0;
            killed       <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            out_rf_we <= 1'b0;
            out_adel  <= 1'b0;
            out_ades  <= 1'b0;
            case (state)
                IDLE: begin
                    if (go_mem) begin
                        state     <= REQ;
                        mem_we    <= dec_st;
                        mem_be    <= be_base << in_addr[OFFW-1:0];
                        mem_addr  <= {in_addr[AW-1:OFFW], {OFFW{1'b0}}};
                        mem_wdata <= st_wdata;
                        ld_q      <= dec_ld;
                        uns_q     <= dec_uns;
                        size_q    <= dec_size;
                        lane_q    <= in_addr[OFFW-1:0];
                        rf_we_q   <= in_rf_we;
                        waddr_q   <= in_rf_waddr;
                        pc_q      <= in_pc;
                        ex_q      <= in_ex_result;
                        killed    <= 1'b0;
                    end else if (accept) begin
                        out_valid    <= 1'b1;
                        out_pc       <= in_pc;
                        out_rf_we    <= in_rf_we & !dec_mis;
                        out_rf_waddr <= in_rf_waddr;
                        out_rf_wdata <= in_ex_result;
                        out_adel     <= dec_mis & dec_ld;
                        out_ades     <= dec_mis & dec_st;
                    end
                end
                REQ: begin
                    if (mem_gnt) begin
                        if (ld_q) begin
                            state  <= RESP;
                            killed <= flush;
                        end else begin
                            state <= IDLE;
                            if (!flush) begin
                                out_valid    <= 1'b1;
                                out_pc       <= pc_q;
                                out_rf_we    <= rf_we_q;
                                out_rf_waddr <= waddr_q;
                                out_rf_wdata <= ex_q;
                            end
                        end
                    end else if (flush) begin
                        state <= IDLE;
                    end
                end
                RESP: begin
                    if (flush) killed <= 1'b1;
                    if (mem_rvalid) begin
                        state <= IDLE;
                        if (!(killed | flush)) begin
                            out_valid    <= 1'b1;
                            out_pc       <= pc_q;
                            out_rf_we    <= rf_we_q;
                            out_rf_waddr <= waddr_q;
                            out_rf_wdata <= ld_data;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign in_ready  = (state == IDLE);
    assign mem_req   = (state == REQ);
    assign stall_req = (state != IDLE) | go_mem;

    // A pending load's value does not exist yet; advertise its destination so ID can stall.
    assign busy    = (state != IDLE) & ld_q & rf_we_q;
    assign fwd_bus = busy ? {1'b1, rf_we_q, waddr_q, {DW{1'b0}}}
                          : {1'b0, out_rf_we, out_rf_waddr, out_rf_wdata};

endmodule

`default_nettype wire

// File: tb/tb_mem_access_stage.sv
// ============================================================================
// Module  : tb_mem_access_stage
// Brief   : Self-checking bench for mem_access_stage (DW=32 and DW=64).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_access_stage;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int tests = 0;
    int fails = 0;

    // 32-bit instance
    logic        flush, in_valid, in_ready, in_rf_we;
    logic [3:0]  in_op;
    logic [31:0] in_addr, in_wdata, in_ex_result, in_pc;
    logic [4:0]  in_rf_waddr;
    logic        mem_req, mem_we, mem_gnt, mem_rvalid;
    logic [3:0]  mem_be;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        out_valid, out_rf_we, out_adel, out_ades, stall_req;
    logic [31:0] out_pc, out_rf_wdata;
    logic [4:0]  out_rf_waddr;
    logic [38:0] fwd_bus;

    // 64-bit instance
    logic        h_in_valid, h_in_ready, h_mem_req, h_mem_we, h_mem_gnt, h_mem_rvalid;
    logic [3:0]  h_in_op;
    logic [31:0] h_in_addr, h_mem_addr, h_out_pc;
    logic [63:0] h_mem_rdata, h_mem_wdata, h_out_rf_wdata;
    logic [7:0]  h_mem_be;
    logic        h_out_valid, h_out_rf_we, h_out_adel, h_out_ades, h_stall_req;
    logic [4:0]  h_out_rf_waddr;
    logic [70:0] h_fwd_bus;

    mem_access_stage #(.DW(32), .AW(32), .RFAW(5)) dut (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .in_op(in_op), .in_addr(in_addr), .in_wdata(in_wdata), .in_ex_result(in_ex_result),
        .in_rf_we(in_rf_we), .in_rf_waddr(in_rf_waddr), .in_pc(in_pc),
        .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .out_valid(out_valid), .out_pc(out_pc), .out_rf_we(out_rf_we), .out_rf_waddr(out_rf_waddr),
        .out_rf_wdata(out_rf_wdata), .out_adel(out_adel), .out_ades(out_ades),
        .stall_req(stall_req), .fwd_bus(fwd_bus)
    );

    mem_access_stage #(.DW(64), .AW(32), .RFAW(5)) dut64 (
        .clk(clk), .rst(rst), .flush(1'b0), .in_valid(h_in_valid), .in_ready(h_in_ready),
        .in_op(h_in_op), .in_addr(h_in_addr), .in_wdata(64'd0), .in_ex_result(64'd0),
        .in_rf_we(1'b1), .in_rf_waddr(5'd3), .in_pc(32'h200),
        .mem_req(h_mem_req), .mem_we(h_mem_we), .mem_be(h_mem_be), .mem_addr(h_mem_addr),
        .mem_wdata(h_mem_wdata), .mem_gnt(h_mem_gnt), .mem_rvalid(h_mem_rvalid), .mem_rdata(h_mem_rdata),
        .out_valid(h_out_valid), .out_pc(h_out_pc), .out_rf_we(h_out_rf_we), .out_rf_waddr(h_out_rf_waddr),
        .out_rf_wdata(h_out_rf_wdata), .out_adel(h_out_adel), .out_ades(h_out_ades),
        .stall_req(h_stall_req), .fwd_bus(h_fwd_bus)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, required %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    typedef struct {
        logic [31:0] pc;
        logic        rf_we;
        logic [4:0]  waddr;
        logic [31:0] wdata;
        logic        wdchk;
        logic        adel;
        logic        ades;
        int          cyc;
    } exp_t;

    exp_t sbq[$];
    exp_t mon_e;

    always @(negedge clk) begin
        if (out_valid) begin
            if (sbq.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_out_valid: got out_valid=1 pc %h, required no output", out_pc);
            end else begin
                mon_e = sbq.pop_front();
                chk("out_pc", out_pc, mon_e.pc);
                chk("out_rf_we", out_rf_we, mon_e.rf_we);
                chk("out_rf_waddr", out_rf_waddr, mon_e.waddr);
                if (mon_e.wdchk) chk("out_rf_wdata", out_rf_wdata, mon_e.wdata);
                chk("out_adel", out_adel, mon_e.adel);
                chk("out_ades", out_ades, mon_e.ades);
                chk("latency_cycle", cyc, mon_e.cyc);
            end
        end
    end

    // kind: 0 = no bus access, 1 = store, 2 = load
    typedef struct {
        logic [3:0]  op;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] ex;
        logic [31:0] rdata;
        logic        we;
        int          gwait;
        int          kind;
        logic [3:0]  be;
        logic [31:0] mwd;
        logic [31:0] rfwd;
        logic        rfwe;
        logic        adel;
        logic        ades;
        logic        wdchk;
    } vec_t;

    localparam int NV = 17;
    vec_t tv[NV];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_vec(input int i);
        vec_t v;
        exp_t e;
        int   lat;
        v = tv[i];
        in_valid     = 1'b1;
        in_op        = v.op;
        in_addr      = v.addr;
        in_wdata     = v.wdata;
        in_ex_result = v.ex;
        in_rf_we     = v.we;
        in_rf_waddr  = 5'(i + 1);
        in_pc        = 32'(32'h100 + 4 * i);
        lat = (v.kind == 0) ? 1 : (v.kind == 1) ? 2 + v.gwait : 3 + v.gwait;
        e = '{pc: in_pc, rf_we: v.rfwe, waddr: in_rf_waddr, wdata: v.rfwd, wdchk: v.wdchk,
              adel: v.adel, ades: v.ades, cyc: cyc + lat};
        sbq.push_back(e);
        #1;
        chk("stall_on_accept", stall_req, v.kind != 0);
        tick();
        in_valid = 1'b0;
        if (v.kind == 0) begin
            chk("no_req", mem_req, 1'b0);
            chk("ready_after_1cyc", in_ready, 1'b1);
        end else begin
            chk("mem_req", mem_req, 1'b1);
            chk("mem_addr", mem_addr, v.addr & 32'hFFFF_FFFC);
            chk("mem_be", mem_be, v.be);
            chk("mem_we", mem_we, v.kind == 1);
            if (v.kind == 1) chk("mem_wdata", mem_wdata, v.mwd);
            chk("ready_busy", in_ready, 1'b0);
            for (int k = 0; k < v.gwait; k++) begin
                tick();
                chk("req_held", mem_req, 1'b1);
                chk("be_held", mem_be, v.be);
                chk("stall_held", stall_req, 1'b1);
            end
            mem_gnt = 1'b1;
            tick();
            mem_gnt = 1'b0;
            if (v.kind == 2) begin
                chk("req_dropped", mem_req, 1'b0);
                chk("fwd_busy", fwd_bus[38], v.we);
                mem_rvalid = 1'b1;
                mem_rdata  = v.rdata;
                tick();
                mem_rvalid = 1'b0;
                mem_rdata  = 32'd0;
            end
            chk("ready_done", in_ready, 1'b1);
        end
        tick();
    endtask

    task automatic accept32(input logic [3:0] op, input logic [31:0] addr, input logic [4:0] wa);
        in_valid    = 1'b1;
        in_op       = op;
        in_addr     = addr;
        in_rf_we    = 1'b1;
        in_rf_waddr = wa;
        in_pc       = 32'h800;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic run64(input logic [3:0] op, input logic [31:0] addr, input logic [63:0] rd,
                         input logic [7:0] be, input logic [63:0] exp, input logic exp_adel);
        h_in_valid = 1'b1;
        h_in_op    = op;
        h_in_addr  = addr;
        tick();
        h_in_valid = 1'b0;
        if (exp_adel) begin
            chk("d64_adel_valid", h_out_valid, 1'b1);
            chk("d64_adel", h_out_adel, 1'b1);
            chk("d64_adel_rfwe", h_out_rf_we, 1'b0);
            chk("d64_adel_noreq", h_mem_req, 1'b0);
        end else begin
            chk("d64_mem_be", h_mem_be, be);
            h_mem_gnt = 1'b1;
            tick();
            h_mem_gnt    = 1'b0;
            h_mem_rvalid = 1'b1;
            h_mem_rdata  = rd;
            tick();
            h_mem_rvalid = 1'b0;
            chk("d64_out_valid", h_out_valid, 1'b1);
            chk("d64_rf_wdata", h_out_rf_wdata, exp);
        end
        tick();
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1);
    end

    initial begin
        //          op     addr          wdata         ex            rdata         we gw kd be     mwd           rfwd          rfwe adel ades wdchk
        tv[0]  = '{4'd1,  32'h0000_1003, 32'h0,        32'h0,        32'h80FF_FF00, 1, 0, 2, 4'h8, 32'h0,        32'hFFFF_FF80, 1, 0, 0, 1};
        tv[1]  = '{4'd2,  32'h0000_1003, 32'h0,        32'h0,        32'h80FF_FF00, 1, 2, 2, 4'h8, 32'h0,        32'h0000_0080, 1, 0, 0, 1};
        tv[2]  = '{4'd3,  32'h0000_1002, 32'h0,        32'h0,        32'h80FF_FF00, 1, 0, 2, 4'hC, 32'h0,        32'hFFFF_80FF, 1, 0, 0, 1};
        tv[3]  = '{4'd4,  32'h0000_1000, 32'h0,        32'h0,        32'h1234_8765, 1, 0, 2, 4'h3, 32'h0,        32'h0000_8765, 1, 0, 0, 1};
        tv[4]  = '{4'd5,  32'h0000_1004, 32'h0,        32'h0,        32'hCAFE_BABE, 1, 1, 2, 4'hF, 32'h0,        32'hCAFE_BABE, 1, 0, 0, 1};
        tv[5]  = '{4'd1,  32'h0000_1001, 32'h0,        32'h0,        32'h0000_7F00, 1, 0, 2, 4'h2, 32'h0,        32'h0000_007F, 1, 0, 0, 1};
        tv[6]  = '{4'd6,  32'h0000_2001, 32'h0000_00A5, 32'h11,      32'h0,        0, 0, 1, 4'h2, 32'hA5A5_A5A5, 32'h0,        0, 0, 0, 0};
        tv[7]  = '{4'd7,  32'h0000_2002, 32'h0000_ABCD, 32'h22,      32'h0,        0, 4, 1, 4'hC, 32'hABCD_ABCD, 32'h0,        0, 0, 0, 0};
        tv[8]  = '{4'd8,  32'h0000_2000, 32'h0123_4567, 32'h33,      32'h0,        0, 0, 1, 4'hF, 32'h0123_4567, 32'h0,        0, 0, 0, 0};
        tv[9]  = '{4'd5,  32'h0000_3001, 32'h0,        32'h44,       32'h0,        1, 0, 0, 4'h0, 32'h0,        32'h0,        0, 1, 0, 0};
        tv[10] = '{4'd7,  32'h0000_3003, 32'h1234,     32'h0,        32'h0,        0, 0, 0, 4'h0, 32'h0,        32'h0,        0, 0, 1, 0};
        tv[11] = '{4'd3,  32'h0000_3001, 32'h0,        32'h0,        32'h0,        1, 0, 0, 4'h0, 32'h0,        32'h0,        0, 1, 0, 0};
        tv[12] = '{4'd0,  32'h0,         32'h0,        32'h55AA,     32'h0,        1, 0, 0, 4'h0, 32'h0,        32'h55AA,     1, 0, 0, 1};
        tv[13] = '{4'd9,  32'h0000_3001, 32'h0,        32'h0BAD,     32'h0,        1, 0, 0, 4'h0, 32'h0,        32'h0BAD,     1, 0, 0, 1};
        tv[14] = '{4'd10, 32'h0000_3003, 32'h0,        32'hC0DE,     32'h0,        1, 0, 0, 4'h0, 32'h0,        32'hC0DE,     1, 0, 0, 1};
        tv[15] = '{4'd13, 32'h0,         32'h0,        32'hFACE,     32'h0,        0, 0, 0, 4'h0, 32'h0,        32'hFACE,     0, 0, 0, 1};
        tv[16] = '{4'd8,  32'h0000_2006, 32'h0,        32'h0,        32'h0,        0, 0, 0, 4'h0, 32'h0,        32'h0,        0, 0, 1, 0};

        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_op = 4'd0; in_addr = '0; in_wdata = '0;
        in_ex_result = '0; in_rf_we = 1'b0; in_rf_waddr = '0; in_pc = '0;
        mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
        h_in_valid = 1'b0; h_in_op = 4'd0; h_in_addr = '0; h_mem_gnt = 1'b0; h_mem_rvalid = 1'b0; h_mem_rdata = '0;
        repeat (3) tick();

        chk("rst_mem_req", mem_req, 1'b0);
        chk("rst_mem_be", mem_be, 4'h0);
        chk("rst_stall", stall_req, 1'b0);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_out_rf_we", out_rf_we, 1'b0);
        chk("rst_in_ready", in_ready, 1'b1);
        chk("rst_fwd_bus", fwd_bus, 39'd0);
        rst = 1'b0;
        tick();

        for (int i = 0; i < NV; i++) run_vec(i);

        // Flush in IDLE rejects the op.
        in_valid = 1'b1; flush = 1'b1; in_op = 4'd5; in_addr = 32'h1000;
        tick();
        in_valid = 1'b0; flush = 1'b0;
        chk("flush_idle_noreq", mem_req, 1'b0);
        chk("flush_idle_ready", in_ready, 1'b1);
        tick();

        // Flush in REQ before grant drops the request; stray gnt/rvalid are ignored.
        accept32(4'd5, 32'h1010, 5'd4);
        chk("freq_req", mem_req, 1'b1);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("freq_dropped", mem_req, 1'b0);
        chk("freq_ready", in_ready, 1'b1);
        mem_gnt = 1'b1;
        tick();
        mem_gnt = 1'b0; mem_rvalid = 1'b1;
        tick();
        mem_rvalid = 1'b0;
        chk("stray_ready", in_ready, 1'b1);
        tick();

        // Flush after grant: load completes silently on rvalid.
        accept32(4'd5, 32'h1020, 5'd6);
        mem_gnt = 1'b1;
        tick();
        mem_gnt = 1'b0; flush = 1'b1;
        chk("fresp_stall", stall_req, 1'b1);
        tick();
        flush = 1'b0;
        chk("fresp_wait", in_ready, 1'b0);
        tick();
        mem_rvalid = 1'b1; mem_rdata = 32'h1111_2222;
        tick();
        mem_rvalid = 1'b0;
        chk("fresp_ready", in_ready, 1'b1);
        chk("fresp_no_out", out_valid, 1'b0);
        tick();

        // Flush with grant in the same cycle on a store.
        accept32(4'd8, 32'h2000, 5'd2);
        mem_gnt = 1'b1; flush = 1'b1;
        tick();
        mem_gnt = 1'b0; flush = 1'b0;
        chk("fgnt_ready", in_ready, 1'b1);
        chk("fgnt_no_out", out_valid, 1'b0);
        tick();

        // Reset while waiting for load data.
        accept32(4'd5, 32'h1030, 5'd9);
        mem_gnt = 1'b1;
        tick();
        mem_gnt = 1'b0;
        chk("fwd_busy_resp", fwd_bus[38:32], 7'b110_1001);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rstm_ready", in_ready, 1'b1);
        chk("rstm_req", mem_req, 1'b0);
        chk("rstm_stall", stall_req, 1'b0);
        chk("rstm_addr", mem_addr, 32'd0);
        chk("rstm_wdata", out_rf_wdata, 32'd0);
        mem_rvalid = 1'b1; mem_rdata = 32'hFFFF_FFFF;
        tick();
        mem_rvalid = 1'b0;
        chk("rstm_stray_rvalid", out_valid, 1'b0);
        tick();

        run64(4'd9,  32'h4004, 64'hDEAD_BEEF_1234_5678, 8'hF0, 64'h0000_0000_DEAD_BEEF, 1'b0);
        run64(4'd10, 32'h4004, 64'h0,                   8'h00, 64'h0,                   1'b1);
        run64(4'd10, 32'h4008, 64'h0123_4567_89AB_CDEF, 8'hFF, 64'h0123_4567_89AB_CDEF, 1'b0);
        run64(4'd5,  32'h400C, 64'h8000_0001_0000_0000, 8'hF0, 64'hFFFF_FFFF_8000_0001, 1'b0);
        run64(4'd3,  32'h4006, 64'hF00D_0000_0000_0000, 8'hC0, 64'hFFFF_FFFF_FFFF_F00D, 1'b0);

        chk("scoreboard_drained", 64'(sbq.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire
